// File: rtl/id_stage_ctrl_pkg.sv
// Shared definitions for the ID stage controller: opcodes, immediate-select
// encodings, FSM state constants and the "instruction reads rt" helper.
package id_stage_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] IMM_ZERO  = 2'b00;
  localparam logic [1:0] IMM_SIGN  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  typedef logic [1:0] id_state_t;
  localparam id_state_t ST_EMPTY = 2'd0;
  localparam id_state_t ST_FULL  = 2'd1;
  localparam id_state_t ST_HAZ   = 2'd2;

  // Only these formats use rt as a source; for the rest rt is a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_stage_ctrl_hazard_det.sv
// Combinational load-use hazard compare between the held ID instruction and
// the load currently in EX.
module id_hazard_det
  import id_stage_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        hazard
);

  logic rs_match_s;
  logic rt_match_s;

  // Writes to $0 are discarded, so a load targeting it never blocks.
  always_comb begin
    rs_match_s = (ex_rt == instr[25:21]);
    rt_match_s = (ex_rt == instr[20:16]) && reads_rt(instr[31:26]);
    hazard     = ex_mem_read && (ex_rt != 5'd0) && (rs_match_s || rt_match_s);
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Single-slot ID stage controller with load-use stall insertion.
// Optional load-use stall counter enabled by macro ID_STALL_CNT_EN.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        ex_ready,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        flush,
  output logic [1:0]  imm_sel,
  output logic [15:0] imm
`ifdef ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  id_state_t   state_r;
  id_state_t   state_nxt_s;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic        hazard_s;
  logic        load_s;

  id_hazard_det u_hazard (
    .instr       (instr_r),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard_s)
  );

  // Next-state and handshake decode; flush overrides everything and drops the fetch word.
  always_comb begin
    state_nxt_s = state_r;
    id_valid    = 1'b0;
    if_ready    = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if_ready = 1'b1;
          if (if_valid) begin
            load_s      = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (hazard_s) begin
            state_nxt_s = ST_HAZ;
          end else begin
            id_valid = 1'b1;
            if (ex_ready) begin
              if_ready = 1'b1;
              if (if_valid) begin
                load_s      = 1'b1;
                state_nxt_s = ST_FULL;
              end else begin
                state_nxt_s = ST_EMPTY;
              end
            end else begin
              state_nxt_s = ST_FULL;
            end
          end
        end
        ST_HAZ:  state_nxt_s = ST_FULL;
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Slot state and held instruction/pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      instr_r <= 32'd0;
      pc_r    <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        instr_r <= if_instr;
        pc_r    <= if_pc;
      end
    end
  end

  assign id_instr = instr_r;
  assign id_pc    = pc_r;
  assign imm      = instr_r[15:0];

  // Immediate extender select from the held opcode.
  always_comb begin
    case (instr_r[31:26])
      OP_ANDI, OP_ORI, OP_XORI:               imm_sel = IMM_ZERO;
      OP_LUI:                                 imm_sel = IMM_UPPER;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE:           imm_sel = IMM_SIGN;
      default:                                imm_sel = IMM_ZERO;
    endcase
  end

`ifdef ID_STALL_CNT_EN
  logic             haz_entry_s;
  logic [CNT_W-1:0] cnt_r;

  assign haz_entry_s = (state_r == ST_FULL) && hazard_s && !flush;

  // Saturating count of stall entries; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (haz_entry_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: directed scenarios plus randomized
// traffic against a slot-level reference model.
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        ex_ready = 1'b1;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        flush = 1'b0;
  logic [1:0]  imm_sel;
  logic [15:0] imm;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // reference model: slot occupancy, pending bubble, held word, stall count
  bit          m_occ = 1'b0;
  bit          m_stall = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc = 32'd0;
  longint      m_cnt = 0;

  always #5 clk = ~clk;

  id_stage_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .ex_ready(ex_ready), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .imm_sel(imm_sel), .imm(imm)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic bit uses_rt(input logic [5:0] op);
    return op inside {6'd0, 6'd4, 6'd5, 6'd43};
  endfunction

  function automatic logic [1:0] want_imm_sel(input logic [5:0] op);
    if (op == 6'd15) return 2'd2;
    if (op inside {6'd8, 6'd9, 6'd10, 6'd11, 6'd35, 6'd43, 6'd4, 6'd5}) return 2'd1;
    return 2'd0;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit er, input bit mr, input logic [4:0] rt, input bit fl);
    if_valid = v; if_instr = ins; if_pc = pc;
    ex_ready = er; ex_mem_read = mr; ex_rt = rt; flush = fl;
  endtask

  // called just after a falling edge with inputs already applied
  task automatic do_cycle();
    bit haz, e_valid, e_ready;
    #1;
    haz = m_occ && !m_stall && ex_mem_read && (ex_rt != 5'd0) &&
          ((ex_rt == m_instr[25:21]) || ((ex_rt == m_instr[20:16]) && uses_rt(m_instr[31:26])));
    e_valid = !flush && m_occ && !m_stall && !haz;
    e_ready = !flush && (!m_occ || (e_valid && ex_ready));
    check_eq("id_valid", {31'd0, id_valid}, {31'd0, e_valid});
    check_eq("if_ready", {31'd0, if_ready}, {31'd0, e_ready});
    if (m_occ) begin
      check_eq("id_instr", id_instr, m_instr);
      check_eq("id_pc", id_pc, m_pc);
      check_eq("imm", {16'd0, imm}, {16'd0, m_instr[15:0]});
      check_eq("imm_sel", {30'd0, imm_sel}, {30'd0, want_imm_sel(m_instr[31:26])});
    end
`ifdef ID_STALL_CNT_EN
    check_eq("stall_cnt", {16'd0, stall_cnt}, m_cnt[31:0]);
`endif
    @(posedge clk);
    if (flush) begin
      m_occ = 1'b0; m_stall = 1'b0;
    end else if (!m_occ) begin
      if (if_valid) begin m_occ = 1'b1; m_instr = if_instr; m_pc = if_pc; end
    end else if (m_stall) begin
      m_stall = 1'b0;
    end else if (haz) begin
      m_stall = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else if (ex_ready) begin
      if (if_valid) begin m_instr = if_instr; m_pc = if_pc; end
      else m_occ = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit er, input bit mr, input logic [4:0] rt, input bit fl);
    set_in(v, ins, pc, er, mr, rt, fl);
    do_cycle();
  endtask

  task automatic model_reset();
    m_occ = 1'b0; m_stall = 1'b0; m_instr = 32'd0; m_pc = 32'd0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    check_eq({tag, "_id_instr"}, id_instr, 32'd0);
    check_eq({tag, "_id_pc"}, id_pc, 32'd0);
    check_eq({tag, "_imm"}, {16'd0, imm}, 32'd0);
    check_eq({tag, "_imm_sel"}, {30'd0, imm_sel}, 32'd0);
`ifdef ID_STALL_CNT_EN
    check_eq({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
  endtask

  localparam logic [31:0] ADD_3_8_9 = 32'h0109_1820;
  logic [5:0] ops [14] = '{6'd0, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                           6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd2};

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    model_reset();
    #1;
    check_eq("rst_if_ready", {31'd0, if_ready}, 32'd1);

    // addi with all-ones immediate
    drive(1'b1, 32'h2008_FFFF, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("addi_valid", {31'd0, id_valid}, 32'd1);
    check_eq("addi_sel", {30'd0, imm_sel}, 32'd1);
    check_eq("addi_imm", {16'd0, imm}, 32'h0000_FFFF);

    // ori then lui back to back, no bubble
    drive(1'b1, 32'h3508_00FF, 32'h104, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("ori_valid", {31'd0, id_valid}, 32'd1);
    check_eq("ori_sel", {30'd0, imm_sel}, 32'd0);
    drive(1'b1, 32'h3C08_1234, 32'h108, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("lui_valid", {31'd0, id_valid}, 32'd1);
    check_eq("lui_sel", {30'd0, imm_sel}, 32'd2);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // load-use on rs
    drive(1'b1, ADD_3_8_9, 32'h200, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 32'h2000_0001, 32'h204, 1'b1, 1'b1, 5'd8, 1'b0);
    drive(1'b1, 32'h2000_0001, 32'h204, 1'b1, 1'b0, 5'd0, 1'b0);
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    check_eq("haz_resume_valid", {31'd0, id_valid}, 32'd1);
    check_eq("haz_resume_instr", id_instr, ADD_3_8_9);
`ifdef ID_STALL_CNT_EN
    check_eq("haz_cnt", {16'd0, stall_cnt}, 32'd1);
`endif
    do_cycle();

    // load into $0 never stalls
    drive(1'b1, ADD_3_8_9, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0);

    // flush while FULL with a fetch offered
    drive(1'b1, 32'h2000_0005, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 32'h2000_0006, 32'h404, 1'b1, 1'b0, 5'd0, 1'b1);
    set_in(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    check_eq("flush_valid", {31'd0, id_valid}, 32'd0);
    check_eq("flush_ready", {31'd0, if_ready}, 32'd1);
    check_eq("flush_not_captured", id_instr, 32'h2000_0005);
    do_cycle();

    // EX back-pressure for three cycles
    drive(1'b1, 32'h8C01_0010, 32'h500, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h2000_0100 + i, 32'h600 + i, 1'b0, 1'b0, 5'd0, 1'b0);
      check_eq("bp_instr", id_instr, 32'h8C01_0010);
      check_eq("bp_ready", {31'd0, if_ready}, 32'd0);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("bp_retired_once", {31'd0, id_valid}, 32'd0);

    // reset while stalled discards the slot
    drive(1'b1, ADD_3_8_9, 32'h700, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_haz");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      op  = ops[$urandom_range(0, 13)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      drive($urandom_range(0, 9) < 7, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
